// File: rtl/fft_bfly_addsub_pkg.sv
// Shared FFT definitions: butterfly FSM state encoding and ALU opcodes.
// The ALU opcodes are also used by the twiddle multiplier stage.
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RA   = 3'd1,
    RS   = 3'd2,
    IA   = 3'd3,
    IS   = 3'd4
  } bf_state_t;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/fft_bfly_addsub.sv
// Radix-2 butterfly combine stage: Y0 = A+P and Y1 = A-P, computed on a shared external ALU.
// Define BF_SCALE_EN to halve each operand (arithmetic shift) as it is loaded into the ALU.
//
// state | meaning
// IDLE  | waiting for a rising edge on bf_en
// RA    | ALU computes REa+REp
// RS    | ALU computes REa-REp
// IA    | ALU computes IMa+IMp
// IS    | ALU computes IMa-IMp; all four results are published
module fft_bfly_addsub
  import fft_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         Clock,
  input  logic         nRst,
  input  logic         bf_en,
  input  logic [n-1:0] REa,
  input  logic [n-1:0] IMa,
  input  logic [n-1:0] REp,
  input  logic [n-1:0] IMp,
  input  logic [n-1:0] out,
  output logic [n-1:0] in_a,
  output logic [n-1:0] in_b,
  output logic         op,
  output logic [n-1:0] Y0RE,
  output logic [n-1:0] Y0IM,
  output logic [n-1:0] Y1RE,
  output logic [n-1:0] Y1IM,
  output logic         busy,
  output logic         done
);

  bf_state_t    r_state;
  logic         r_p;
  logic [n-1:0] r_ima;
  logic [n-1:0] r_imp;
  logic [n-1:0] r_t0re;
  logic [n-1:0] r_t1re;
  logic [n-1:0] r_t0im;
  logic         w_start;

  function automatic logic [n-1:0] scale(input logic [n-1:0] x);
`ifdef BF_SCALE_EN
    return {x[n-1], x[n-1:1]};
`else
    return x;
`endif
  endfunction

  assign w_start = bf_en && !r_p;

  always_ff @(posedge Clock or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
      r_p     <= 1'b0;
      r_ima   <= '0;
      r_imp   <= '0;
      r_t0re  <= '0;
      r_t1re  <= '0;
      r_t0im  <= '0;
      in_a    <= '0;
      in_b    <= '0;
      op      <= 1'b0;
      Y0RE    <= '0;
      Y0IM    <= '0;
      Y1RE    <= '0;
      Y1IM    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_p  <= bf_en;
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          // The real parts go straight into the operand registers, which act as their latch.
          if (w_start) begin
            r_ima   <= IMa;
            r_imp   <= IMp;
            in_a    <= scale(REa);
            in_b    <= scale(REp);
            op      <= OP_ADD;
            busy    <= 1'b1;
            r_state <= RA;
          end
        end
        RA: begin
          r_t0re  <= out;
          op      <= OP_SUB;
          r_state <= RS;
        end
        RS: begin
          r_t1re  <= out;
          in_a    <= scale(r_ima);
          in_b    <= scale(r_imp);
          op      <= OP_ADD;
          r_state <= IA;
        end
        IA: begin
          r_t0im  <= out;
          op      <= OP_SUB;
          r_state <= IS;
        end
        IS: begin
          Y0RE    <= r_t0re;
          Y1RE    <= r_t1re;
          Y0IM    <= r_t0im;
          Y1IM    <= out;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
